dmem_responder: RTL and testbench

- Data-memory responder for the `mem_in`/`mem_out` request interface driven by the decode stage's `dmem_in` port. It is the far end of that protocol.
- Accepts one request at a time. Applies a programmable number of wait states, then performs a word-wide SRAM read or byte-strobed write.
- Returns exactly one `mem_ready` pulse per request, with read data and an error flag.
- Sits between the core's data port and on-chip scratchpad RAM. It also serves as the bench memory model for core integration.

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one mem_in request at a time, waits LATENCY cycles,
// then performs a word read or byte-strobed write on a local scratchpad array.
module dmem_responder #(
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          LATENCY    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_error
);

   if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 0..15");
   end
   if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
      $error("dmem_responder: BASE_ADDR must be 4-byte aligned");
   end

   localparam logic [3:0]  LAT4 = 4'(LATENCY);
   localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_nxt;
   logic                  w_capture;
   logic [31:0]           r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_instr;
   logic                  r_ready;
   logic                  r_error;
   logic [31:0]           r_rdata;
   logic [31:0]           r_mem [0:(1<<DEPTH_LOG2)-1];

   logic [31:0]           w_offset;
   logic                  w_in_range;
   logic                  w_error;
   logic                  w_is_write;
   logic                  w_access;
   logic [DEPTH_LOG2-1:0] w_index;

   // Address decode of the captured request; addresses below BASE_ADDR wrap to huge offsets.
   assign w_offset   = r_addr - BASE_ADDR;
   assign w_in_range = ({1'b0, w_offset} < SPAN);
   assign w_is_write = (r_wstrb != 4'h0);
   assign w_error    = !w_in_range || (r_instr && w_is_write);
   assign w_index    = w_offset[DEPTH_LOG2+1:2];
   assign w_access   = (r_state == S_ACCESS);

   // Next-state and wait-counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_valid) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = LAT4;
               w_state_nxt = (LAT4 != 4'd0) ? S_WAIT : S_ACCESS;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (r_cnt <= 4'd1) begin
               w_cnt_nxt   = 4'd0;
               w_state_nxt = S_ACCESS;
            end else begin
               w_cnt_nxt   = r_cnt - 4'd1;
            end
         end
         S_ACCESS: w_state_nxt = S_RESP;
         S_RESP:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // State, counter and captured-request registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_wstrb <= 4'h0;
         r_instr <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_capture) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_instr <= mem_instr;
         end
      end
   end

   // Response registers: loaded while leaving ACCESS so they are visible for the RESP cycle only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ready <= 1'b0;
         r_error <= 1'b0;
         r_rdata <= 32'h0;
      end else if (w_access) begin
         r_ready <= 1'b1;
         r_error <= w_error;
         r_rdata <= (w_error || w_is_write) ? 32'h0 : r_mem[w_index];
      end else begin
         r_ready <= 1'b0;
         r_error <= 1'b0;
         r_rdata <= 32'h0;
      end
   end

   // Scratchpad write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (rst && w_access && !w_error) begin
         for (int i = 0; i < 4; i++) begin
            if (r_wstrb[i]) begin
               r_mem[w_index][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

   assign mem_ready = r_ready;
   assign mem_error = r_error;
   assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench for dmem_responder: four instances cover LATENCY 0/1/15 and a
// non-zero BASE_ADDR; hand sequences cover reset and mid-request abort.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  valid = 4'h0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [3:0]  mem_wstrb = 4'h0;
   logic [3:0]  ready;
   logic [3:0]  err;
   logic [31:0] rdata [4];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .mem_valid(valid[0]), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready[0]), .mem_rdata(rdata[0]),
      .mem_error(err[0]));
   dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0000_1000), .LATENCY(1)) u_base (
      .clk(clk), .rst(rst), .mem_valid(valid[1]), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready[1]), .mem_rdata(rdata[1]),
      .mem_error(err[1]));
   dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0000_0000), .LATENCY(0)) u_l0 (
      .clk(clk), .rst(rst), .mem_valid(valid[2]), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready[2]), .mem_rdata(rdata[2]),
      .mem_error(err[2]));
   dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0000_0000), .LATENCY(15)) u_l15 (
      .clk(clk), .rst(rst), .mem_valid(valid[3]), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready[3]), .mem_rdata(rdata[3]),
      .mem_error(err[3]));

   typedef struct {
      int          sel;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        chg;
      logic [31:0] alt;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic        chk_rd;
   } vec_t;

   localparam int NV = 20;
   vec_t tbl [NV];

   function automatic int lat_of(input int sel);
      case (sel)
         0:       return 3;
         1:       return 3;
         2:       return 2;
         3:       return 17;
         default: return 0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, wanted %h", name, act, exp);
      end
   endtask

   // One request on instance sel; lat counts cycles from the accepting cycle to mem_ready.
   task automatic run_req(input int sel, input logic instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic chg, input logic [31:0] alt,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic one_shot);
      logic done;
      done = 1'b0;
      rd = 32'h0;
      er = 1'b0;
      @(negedge clk);
      mem_instr = instr;
      mem_addr = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      valid[sel] = 1'b1;
      lat = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         lat++;
         if (chg && lat == 1) mem_addr = alt;
         if (ready[sel]) begin
            done = 1'b1;
            rd = rdata[sel];
            er = err[sel];
         end
      end
      valid[sel] = 1'b0;
      if (!done) lat = -1;
      @(negedge clk);
      one_shot = !ready[sel];
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        one_shot;
      int          seen;

      tbl[0]  = '{0, 1'b0, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1};
      tbl[1]  = '{0, 1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 32'h0,   32'hDEADBEEF, 1'b0, 1'b1};
      tbl[2]  = '{0, 1'b0, 32'h20,   32'h11223344, 4'hF, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1};
      tbl[3]  = '{0, 1'b0, 32'h20,   32'hAA00BB00, 4'hA, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1};
      tbl[4]  = '{0, 1'b0, 32'h20,   32'h0,        4'h0, 1'b0, 32'h0,   32'hAA22BB44, 1'b0, 1'b1};
      tbl[5]  = '{1, 1'b0, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1};
      tbl[6]  = '{1, 1'b0, 32'h5000, 32'h99999999, 4'hF, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};
      tbl[7]  = '{1, 1'b0, 32'h0FFC, 32'h0,        4'h0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};
      tbl[8]  = '{1, 1'b0, 32'h1000, 32'h0,        4'h0, 1'b0, 32'h0,   32'hCAFEF00D, 1'b0, 1'b1};
      tbl[9]  = '{1, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1};
      tbl[10] = '{1, 1'b1, 32'h1000, 32'h0,        4'h0, 1'b0, 32'h0,   32'hCAFEF00D, 1'b0, 1'b1};
      tbl[11] = '{1, 1'b0, 32'h4FFC, 32'h0,        4'h0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0};
      tbl[12] = '{2, 1'b0, 32'h44,   32'h55555555, 4'hF, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1};
      tbl[13] = '{2, 1'b0, 32'h40,   32'h0BADCAFE, 4'hF, 1'b1, 32'h44,  32'h0,        1'b0, 1'b1};
      tbl[14] = '{2, 1'b0, 32'h40,   32'h0,        4'h0, 1'b0, 32'h0,   32'h0BADCAFE, 1'b0, 1'b1};
      tbl[15] = '{2, 1'b0, 32'h44,   32'h0,        4'h0, 1'b1, 32'h40,  32'h55555555, 1'b0, 1'b1};
      tbl[16] = '{3, 1'b0, 32'h84,   32'h66666666, 4'hF, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1};
      tbl[17] = '{3, 1'b0, 32'h80,   32'h0FEEDBEE, 4'hF, 1'b1, 32'h84,  32'h0,        1'b0, 1'b1};
      tbl[18] = '{3, 1'b0, 32'h80,   32'h0,        4'h0, 1'b0, 32'h0,   32'h0FEEDBEE, 1'b0, 1'b1};
      tbl[19] = '{3, 1'b0, 32'h84,   32'h0,        4'h0, 1'b1, 32'h80,  32'h66666666, 1'b0, 1'b1};

      // Reset held with a request pending: nothing may respond.
      rst = 1'b0;
      valid[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("reset_ready", {28'h0, ready}, 32'h0);
         check("reset_rdata0", rdata[0], 32'h0);
         check("reset_error", {28'h0, err}, 32'h0);
      end
      rst = 1'b1;
      valid[0] = 1'b0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (ready != 4'h0) seen++;
      end
      check("idle_no_ready", seen, 0);

      for (int v = 0; v < NV; v++) begin
         run_req(tbl[v].sel, tbl[v].instr, tbl[v].addr, tbl[v].wdata, tbl[v].wstrb,
                 tbl[v].chg, tbl[v].alt, rd, er, lat, one_shot);
         check($sformatf("v%0d_latency", v), lat, lat_of(tbl[v].sel));
         check($sformatf("v%0d_error", v), {31'h0, er}, {31'h0, tbl[v].exp_err});
         check($sformatf("v%0d_one_shot", v), {31'h0, one_shot}, 32'h1);
         if (tbl[v].chk_rd) check($sformatf("v%0d_rdata", v), rd, tbl[v].exp_rd);
      end

      // Abort a LATENCY=15 write mid-WAIT; the word must keep its old value.
      @(negedge clk);
      mem_instr = 1'b0;
      mem_addr = 32'h84;
      mem_wdata = 32'h77777777;
      mem_wstrb = 4'hF;
      valid[3] = 1'b1;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (ready[3]) seen++;
      end
      rst = 1'b0;
      valid[3] = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (ready[3]) seen++;
      end
      rst = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (ready[3]) seen++;
      end
      check("abort_no_ready", seen, 0);
      run_req(3, 1'b0, 32'h84, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, lat, one_shot);
      check("abort_rdata", rd, 32'h66666666);
      check("abort_error", {31'h0, er}, 32'h0);
      check("abort_latency", lat, 17);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
